// File: rtl/seq_shift_add_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_shift_add_mult_pkg;

  // Controller states: waiting for a request, or stepping through partial products.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Ceiling log2, used to size the iteration counter so it can hold n-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/mult_add_shift_step.sv
// One iteration of the shift-add algorithm: conditionally add the multiplicand
// into the upper accumulator, then shift {acc_hi, acc_lo, mplier} right by one.
module mult_add_shift_step #(
  parameter int n = 8
) (
  input  logic [n:0]   acc_hi,
  input  logic [n-1:0] acc_lo,
  input  logic [n-1:0] mplier,
  input  logic [n-1:0] mcand,
  output logic [n:0]   acc_hi_next,
  output logic [n-1:0] acc_lo_next,
  output logic [n-1:0] mplier_next
);

  logic [n:0] sum;

  // Add-then-shift; acc_hi stays below 2^n between steps, so n+1 bits never overflow.
  always_comb begin
    // NOTE: every output of a combinational block is assigned on every path;
    // a path that leaves one untouched makes the tool infer a latch.
    sum = acc_hi;
    if (mplier[0]) begin
      sum = acc_hi + {1'b0, mcand};
    end
    {acc_hi_next, acc_lo_next, mplier_next} = {1'b0, sum, acc_lo, mplier[n-1:1]};
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential n x n shift-add multiplier with start/done handshake.
// Operands are reduced to magnitudes, multiplied unsigned over n cycles,
// and the sign is reapplied on the final step.
module seq_shift_add_mult
  import seq_shift_add_mult_pkg::*;
#(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [n-1:0]   A,
  input  logic [n-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*n-1:0] Z
);

  localparam int CNT_W = clog2(n);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [n-1:0]       mcand;
  logic [n-1:0]       mplier;
  logic [n:0]         acc_hi;
  logic [n-1:0]       acc_lo;
  logic               neg;

  logic [n-1:0]       mag_a;
  logic [n-1:0]       mag_b;
  logic [n:0]         acc_hi_next;
  logic [n-1:0]       acc_lo_next;
  logic [n-1:0]       mplier_next;
  logic [2*n-1:0]     prod;
  logic               last_step;

  // Magnitudes of the operands; -2^(n-1) maps to 2^(n-1), which is exact as unsigned.
  always_comb begin
    mag_a = A;
    mag_b = B;
    if (signed_mode && A[n-1]) mag_a = -A;
    if (signed_mode && B[n-1]) mag_b = -B;
  end

  mult_add_shift_step #(.n(n)) u_step (
    .acc_hi      (acc_hi),
    .acc_lo      (acc_lo),
    .mplier      (mplier),
    .mcand       (mcand),
    .acc_hi_next (acc_hi_next),
    .acc_lo_next (acc_lo_next),
    .mplier_next (mplier_next)
  );

  // After the n-th step the full unsigned product sits in {acc_hi, acc_lo}.
  assign prod      = {acc_hi_next[n-1:0], acc_lo_next};
  assign last_step = (cnt == CNT_W'(n - 1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept a request when idle, return to idle after n steps.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start)     state_next = ST_RUN;
      ST_RUN:  if (last_step) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, per-cycle step, sign fix-up and handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      Z      <= '0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= signed_mode & (A[n-1] ^ B[n-1]);
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
          end
        end
        ST_RUN: begin
          acc_hi <= acc_hi_next;
          acc_lo <= acc_lo_next;
          mplier <= mplier_next;
          cnt    <= cnt + 1'b1;
          if (last_step) begin
            Z    <= neg ? -prod : prod;
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench: directed n=4 scenarios plus an n=8 random sweep.
module tb_seq_shift_add_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: value read at a falling edge equals the number of rising edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // n = 4 instance
  logic       rst4, start4, sm4, busy4, done4;
  logic [3:0] A4, B4;
  logic [7:0] Z4;

  // n = 8 instance
  logic        rst8, start8, sm8, busy8, done8;
  logic [7:0]  A8, B8;
  logic [15:0] Z8;

  seq_shift_add_mult #(.n(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .signed_mode(sm4),
    .A(A4), .B(B4), .busy(busy4), .done(done4), .Z(Z4)
  );

  seq_shift_add_mult #(.n(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .signed_mode(sm8),
    .A(A8), .B(B8), .busy(busy8), .done(done8), .Z(Z8)
  );

  typedef struct {
    logic [15:0] z;
    int          t;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference product of w-bit operands, truncated to 2w bits.
  function automatic logic [15:0] ref_mult(input logic [7:0] a, input logic [7:0] b,
                                           input logic sm, input int w);
    int av, bv, p;
    av = int'(a);
    bv = int'(b);
    if (sm && a[w-1]) av = av - (1 << w);
    if (sm && b[w-1]) bv = bv - (1 << w);
    p = av * bv;
    return 16'(p & ((1 << (2 * w)) - 1));
  endfunction

  // Scoreboard for n=4: every done pulse must match the oldest pending op.
  always @(negedge clk) begin
    if (done4) begin
      check("done4_pending", 32'(q4.size() != 0), 1);
      if (q4.size() != 0) begin
        e4 = q4.pop_front();
        check("z4", 32'(Z4), 32'(e4.z));
        check("latency4", 32'(cyc), 32'(e4.t + 4));
        check("busy_with_done4", 32'(busy4), 0);
      end
    end
  end

  // Scoreboard for n=8.
  always @(negedge clk) begin
    if (done8) begin
      check("done8_pending", 32'(q8.size() != 0), 1);
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        check("z8", 32'(Z8), 32'(e8.z));
        check("latency8", 32'(cyc), 32'(e8.t + 8));
        check("busy_with_done8", 32'(busy8), 0);
      end
    end
  end

  // Drive a request now (caller is at a falling edge) and record its expectation.
  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                        input logic [7:0] exp);
    A4 = a; B4 = b; sm4 = sm; start4 = 1'b1;
    q4.push_back('{z: 16'(exp), t: cyc + 1});
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                        input logic [7:0] exp);
    @(negedge clk);
    drive4(a, b, sm, exp);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    @(negedge clk);
    A8 = a; B8 = b; sm8 = sm; start8 = 1'b1;
    q8.push_back('{z: ref_mult(a, b, sm, 8), t: cyc + 1});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done4();
    int i;
    i = 0;
    while (!done4 && i < 40) begin
      @(negedge clk);
      i++;
    end
    check("done4_seen", 32'(done4), 1);
  endtask

  task automatic wait_done8();
    int i;
    i = 0;
    while (!done8 && i < 40) begin
      @(negedge clk);
      i++;
    end
    check("done8_seen", 32'(done8), 1);
  endtask

  task automatic drain4();
    for (int i = 0; i < 40 && q4.size() > 0; i++) @(negedge clk);
    check("drain4", 32'(q4.size()), 0);
  endtask

  task automatic drain8();
    for (int i = 0; i < 40 && q8.size() > 0; i++) @(negedge clk);
    check("drain8", 32'(q8.size()), 0);
  endtask

  logic [7:0] corners[5];

  initial begin
    rst4 = 1'b1; start4 = 1'b0; sm4 = 1'b0; A4 = '0; B4 = '0;
    rst8 = 1'b1; start8 = 1'b0; sm8 = 1'b0; A8 = '0; B8 = '0;
    corners[0] = 8'h00; corners[1] = 8'h01; corners[2] = 8'h7F;
    corners[3] = 8'h80; corners[4] = 8'hFF;

    // Reset state, with start asserted to show reset wins.
    @(negedge clk);
    start4 = 1'b1; start8 = 1'b1; A4 = 4'hF; B4 = 4'hF; A8 = 8'hFF; B8 = 8'hFF;
    repeat (2) @(negedge clk);
    check("rst_busy4", 32'(busy4), 0);
    check("rst_done4", 32'(done4), 0);
    check("rst_z4",    32'(Z4),    0);
    check("rst_busy8", 32'(busy8), 0);
    check("rst_done8", 32'(done8), 0);
    check("rst_z8",    32'(Z8),    0);
    start4 = 1'b0; start8 = 1'b0;
    rst4 = 1'b0; rst8 = 1'b0;

    // Unsigned: 14 * 3 = 42.
    issue4(4'b1110, 4'b0011, 1'b0, 8'h2A);
    check("busy4_running", 32'(busy4), 1);
    wait_done4();
    drain4();

    // Signed products, including the most-negative operand and a zero operand.
    issue4(4'b1110, 4'b0011, 1'b1, 8'hFA);
    wait_done4();
    issue4(4'b1000, 4'b1000, 1'b1, 8'h40);
    wait_done4();
    issue4(4'b1000, 4'b0111, 1'b1, 8'hC8);
    wait_done4();
    issue4(4'b0000, 4'b1001, 1'b1, 8'h00);
    wait_done4();
    drain4();

    // Start pulsed while busy with different operands: must be ignored.
    issue4(4'b0101, 4'b0110, 1'b0, 8'h1E);
    A4 = 4'b1111; B4 = 4'b1111; sm4 = 1'b1; start4 = 1'b1;
    repeat (2) @(negedge clk);
    start4 = 1'b0;
    wait_done4();
    @(negedge clk);
    check("done4_one_pulse", 32'(done4), 0);
    check("z4_hold", 32'(Z4), 32'h1E);
    drain4();

    // Back-to-back: new start in the done cycle.
    issue4(4'b1111, 4'b1111, 1'b1, 8'h01);
    wait_done4();
    drive4(4'b1100, 4'b1111, 1'b0, 8'hB4);
    @(negedge clk);
    start4 = 1'b0;
    check("done4_falls", 32'(done4), 0);
    check("busy4_b2b", 32'(busy4), 1);
    wait_done4();
    drain4();

    // Reset at cnt=2: op abandoned, no done pulse afterwards.
    @(negedge clk);
    A4 = 4'b0111; B4 = 4'b0111; sm4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (2) @(negedge clk);
    check("busy4_mid", 32'(busy4), 1);
    rst4 = 1'b1;
    @(negedge clk);
    check("rst_mid_busy4", 32'(busy4), 0);
    check("rst_mid_done4", 32'(done4), 0);
    check("rst_mid_z4",    32'(Z4),    0);
    rst4 = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid_idle4", 32'(busy4), 0);

    // n=8: all corner-operand pairs in both modes.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          issue8(corners[i], corners[j], m[0]);
          wait_done8();
        end
      end
    end

    // n=8 random sweep, both modes.
    for (int k = 0; k < 1000; k++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom));
      wait_done8();
    end
    drain8();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
